// File: rtl/csa_pkg.sv
// Shared CSA constants, schedule FSM encoding and the key byte-extraction rule.
// Pure declarations, no logic.
// No handshake involvement.
package csa_pkg;

   localparam int NGRP     = 7;
   localparam int KK_BYTES = 8 * NGRP;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      STREAM = 2'd2
   } state_t;

   // Byte j of a 64-bit key word lives in bits [63-8j:56-8j] (byte 0 is the MSB byte).
   function automatic logic [7:0] key_byte(input logic [63:0] w, input logic [2:0] j);
      return w[63 - 8*int'(j) -: 8];
   endfunction

endpackage

// File: rtl/key_sched_rev_key_perm.sv
// CSA 64-bit key bit permutation, one application per evaluation.
// Purely combinational, zero latency.
// No handshake involvement.
module key_perm (
   input  logic [63:0] i_key,
   output logic [63:0] o_key
);

   // Entry p gives the 1-based destination position of source position p,
   // where position p is bit (7 - p%8) of byte p/8, i.e. word bit 63-p.
   localparam int PERM [64] = '{
      'h12, 'h24, 'h09, 'h07, 'h2A, 'h31, 'h1D, 'h15,
      'h1C, 'h36, 'h3E, 'h32, 'h13, 'h21, 'h3B, 'h40,
      'h18, 'h14, 'h25, 'h27, 'h02, 'h35, 'h1B, 'h01,
      'h22, 'h04, 'h0D, 'h0E, 'h39, 'h28, 'h1A, 'h29,
      'h33, 'h23, 'h34, 'h0C, 'h16, 'h30, 'h1E, 'h3A,
      'h2D, 'h1F, 'h08, 'h19, 'h17, 'h2F, 'h3D, 'h11,
      'h3C, 'h05, 'h38, 'h2B, 'h0B, 'h06, 'h0A, 'h2C,
      'h20, 'h3F, 'h2E, 'h0F, 'h03, 'h26, 'h10, 'h37
   };

   // Route every source bit to its destination; pure wiring after elaboration.
   always_comb begin
      o_key = '0;
      for (int p = 0; p < 64; p++) begin
         o_key[64 - PERM[p]] = i_key[63 - p];
      end
   end

endmodule

// File: rtl/key_sched_rev.sv
// Expands a 64-bit common key into the 56-byte CSA block schedule and streams kk[55]..kk[0].
// 6 expansion cycles; first byte valid 7 cycles after key acceptance, then 1 byte/cycle.
// Stream holds o_kk/o_kk_idx while i_kk_ready is low; keys are only taken when idle.
module key_sched_rev #(
   parameter int NGRP = 7
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_key_valid,
   input  logic [63:0] i_key,
   output logic        o_key_ready,
   output logic        o_kk_valid,
   output logic [7:0]  o_kk,
   output logic [5:0]  o_kk_idx,
   input  logic        i_kk_ready
);

   import csa_pkg::*;

   localparam logic [5:0] IDX_LAST = 6'(8*NGRP - 1);
   localparam logic [2:0] CNT_LOAD = 3'(NGRP - 2);

   state_t      state;
   state_t      state_nxt;
   logic [2:0]  cnt;
   logic [5:0]  idx;
   logic [63:0] grp [NGRP];
   logic [63:0] perm_in;
   logic [63:0] perm_out;
   logic [63:0] sel_word;

   // The permutation always works on the word stored in the previous cycle.
   assign perm_in = grp[cnt + 3'd1];

   key_perm u_perm (
      .i_key (perm_in),
      .o_key (perm_out)
   );

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state: idle until a key, six expansion steps, then stream until byte 0 is taken.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_key_valid)                state_nxt = EXPAND;
         EXPAND:  if (cnt == 3'd0)                state_nxt = STREAM;
         STREAM:  if (i_kk_ready && idx == 6'd0)  state_nxt = IDLE;
         default:                                 state_nxt = IDLE;
      endcase
   end

   // Expansion counter and stream index.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt <= '0;
         idx <= '0;
      end else begin
         case (state)
            IDLE:    if (i_key_valid) cnt <= CNT_LOAD;
            EXPAND:  if (cnt != 3'd0) cnt <= cnt - 3'd1;
                     else             idx <= IDX_LAST;
            STREAM:  if (i_kk_ready && idx != 6'd0) idx <= idx - 6'd1;
            default: ;
         endcase
      end
   end

   // Group word storage; contents are meaningless until a key has been expanded.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         if (state == IDLE && i_key_valid) grp[NGRP-1] <= i_key;
         else if (state == EXPAND)         grp[cnt]    <= perm_out;
      end
   end

   // Outputs: state decode plus byte select/XOR from the stored group words.
   always_comb begin
      sel_word    = grp[idx[5:3]];
      o_key_ready = (state == IDLE);
      o_kk_valid  = (state == STREAM);
      o_kk        = '0;
      o_kk_idx    = '0;
      if (state == STREAM) begin
         o_kk     = key_byte(sel_word, idx[2:0]) ^ {5'b0, idx[5:3]};
         o_kk_idx = idx;
      end
   end

endmodule

// File: tb/tb_key_sched_rev.sv
// Directed-plus-random bench for key_sched_rev against a byte-level CSA key schedule model.
// Checks reset values, latency, stream contents/order, stalls, busy-ignore, abort and back-to-back keys.
// Consumer readiness is randomised per cycle in the backpressure runs.
module tb_key_sched_rev;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_key_valid;
   logic [63:0] i_key;
   logic        o_key_ready;
   logic        o_kk_valid;
   logic [7:0]  o_kk;
   logic [5:0]  o_kk_idx;
   logic        i_kk_ready;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] exp_kk [56];

   localparam int TBL [64] = '{
      'h12, 'h24, 'h09, 'h07, 'h2A, 'h31, 'h1D, 'h15, 'h1C, 'h36, 'h3E, 'h32, 'h13, 'h21, 'h3B, 'h40,
      'h18, 'h14, 'h25, 'h27, 'h02, 'h35, 'h1B, 'h01, 'h22, 'h04, 'h0D, 'h0E, 'h39, 'h28, 'h1A, 'h29,
      'h33, 'h23, 'h34, 'h0C, 'h16, 'h30, 'h1E, 'h3A, 'h2D, 'h1F, 'h08, 'h19, 'h17, 'h2F, 'h3D, 'h11,
      'h3C, 'h05, 'h38, 'h2B, 'h0B, 'h06, 'h0A, 'h2C, 'h20, 'h3F, 'h2E, 'h0F, 'h03, 'h26, 'h10, 'h37
   };

   key_sched_rev dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_key_valid (i_key_valid),
      .i_key       (i_key),
      .o_key_ready (o_key_ready),
      .o_kk_valid  (o_kk_valid),
      .o_kk        (o_kk),
      .o_kk_idx    (o_kk_idx),
      .i_kk_ready  (i_kk_ready)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Byte-array formulation of the CSA key permutation, as in the C reference.
   function automatic logic [63:0] model_perm(input logic [63:0] w);
      int          kin [8];
      int          kout [8];
      int          b;
      int          nb;
      logic [63:0] r;
      for (int j = 0; j < 8; j++) begin
         kin[j]  = int'((w >> (56 - 8*j)) & 64'hFF);
         kout[j] = 0;
      end
      for (int j = 0; j < 8; j++) begin
         for (int k = 0; k < 8; k++) begin
            b  = (kin[j] >> (7 - k)) & 1;
            nb = TBL[j*8 + k] - 1;
            kout[nb / 8] = kout[nb / 8] | (b << (7 - (nb % 8)));
         end
      end
      r = '0;
      for (int j = 0; j < 8; j++) r = (r << 8) | 64'(kout[j]);
      return r;
   endfunction

   task automatic build_exp(input logic [63:0] key);
      logic [63:0] w [7];
      w[6] = key;
      for (int g = 5; g >= 0; g--) w[g] = model_perm(w[g+1]);
      for (int i = 0; i < 56; i++) begin
         exp_kk[i] = 8'((w[i/8] >> (56 - 8*(i%8))) & 64'hFF) ^ 8'(i/8);
      end
   endtask

   // Offer one key, check latency and the whole stream (or abort after a given byte).
   task automatic run_key(input logic [63:0] key, input int rdy_pct, input int abort_at, input bit busy);
      int lat;
      int exp_idx;
      int guard;
      build_exp(key);
      guard = 0;
      while (!o_key_ready && guard < 200) begin
         @(negedge i_clk);
         guard++;
      end
      check("key_ready_before_key", 64'(o_key_ready), 64'd1);
      i_key       = key;
      i_key_valid = 1'b1;
      @(negedge i_clk);
      i_key_valid = 1'b0;
      i_key       = {$urandom, $urandom};
      check("key_ready_low_after_accept", 64'(o_key_ready), 64'd0);
      lat = 1;
      while (!o_kk_valid && lat < 20) begin
         if (busy && lat == 3) begin
            i_key_valid = 1'b1;
            i_key       = 64'h1122334455667788;
         end else begin
            i_key_valid = 1'b0;
         end
         @(negedge i_clk);
         lat++;
      end
      i_key_valid = 1'b0;
      check("first_byte_latency", 64'(lat), 64'd7);
      exp_idx = 55;
      guard   = 0;
      while (exp_idx >= 0 && guard < 2000) begin
         if (abort_at >= 0 && exp_idx == abort_at - 1) begin
            i_rst       = 1'b1;
            i_key_valid = 1'b1;
            i_kk_ready  = 1'b1;
            @(negedge i_clk);
            i_rst       = 1'b0;
            i_key_valid = 1'b0;
            check("abort_kk_valid", 64'(o_kk_valid), 64'd0);
            check("abort_key_ready", 64'(o_key_ready), 64'd1);
            check("abort_kk_idx", 64'(o_kk_idx), 64'd0);
            check("abort_kk", 64'(o_kk), 64'd0);
            return;
         end
         check($sformatf("kk_valid[%0d]", exp_idx), 64'(o_kk_valid), 64'd1);
         check($sformatf("kk_idx[%0d]", exp_idx), 64'(o_kk_idx), 64'(exp_idx));
         check($sformatf("kk_byte[%0d]", exp_idx), 64'(o_kk), 64'(exp_kk[exp_idx]));
         check($sformatf("key_ready_busy[%0d]", exp_idx), 64'(o_key_ready), 64'd0);
         i_kk_ready = ($urandom_range(99) < rdy_pct);
         if (busy && exp_idx == 40) begin
            i_key_valid = 1'b1;
            i_key       = 64'h1122334455667788;
         end else begin
            i_key_valid = 1'b0;
         end
         @(posedge i_clk);
         if (i_kk_ready) exp_idx--;
         @(negedge i_clk);
         guard++;
      end
      i_key_valid = 1'b0;
      i_kk_ready  = 1'($urandom_range(1));
      check("stream_completed", 64'(exp_idx < 0), 64'd1);
      check("idle_key_ready", 64'(o_key_ready), 64'd1);
      check("idle_kk_valid", 64'(o_kk_valid), 64'd0);
      check("idle_kk_idx", 64'(o_kk_idx), 64'd0);
   endtask

   initial begin
      i_rst       = 1'b1;
      i_key_valid = 1'b1;
      i_key       = 64'hDEADBEEFCAFEF00D;
      i_kk_ready  = 1'b0;
      repeat (3) @(negedge i_clk);
      check("rst_key_ready", 64'(o_key_ready), 64'd1);
      check("rst_kk_valid", 64'(o_kk_valid), 64'd0);
      check("rst_kk", 64'(o_kk), 64'd0);
      check("rst_kk_idx", 64'(o_kk_idx), 64'd0);
      i_rst       = 1'b0;
      i_key_valid = 1'b0;
      @(negedge i_clk);
      check("post_rst_idle", 64'(o_key_ready), 64'd1);
      i_kk_ready = 1'b1;

      run_key(64'h0, 100, -1, 1'b0);
      run_key(64'hFFFFFFFFFFFFFFFF, 100, -1, 1'b0);
      run_key(64'h0, 100, -1, 1'b1);
      run_key({$urandom, $urandom}, 70, 30, 1'b0);
      run_key(64'hFFFFFFFFFFFFFFFF, 100, -1, 1'b0);
      for (int n = 0; n < 6; n++) begin
         run_key({$urandom, $urandom}, 60, -1, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/key_sched_rev.md
# key_sched_rev

Reverse-order streaming key-schedule generator for the CSA block decipher. It accepts one 64-bit common key and expands it into the 56-byte block-cipher key schedule by applying the 64-bit key permutation iteratively. It then streams the schedule bytes out in descending index order (kk[55] first, kk[0] last), which is the order the block decipher consumes them. It sits between the key register interface and the block decipher round engine.

## Interface
- NGRP, 7, number of 8-byte schedule groups; schedule length is 8*NGRP bytes. Only 7 is verified.
- i_clk  in  1  rising-edge clock
- i_rst  in  1  synchronous, active-high reset
- i_key_valid  in  1  new key offered
- i_key  in  64  common key; byte j = bits [63-8j:56-8j]
- o_key_ready  out  1  block idle, will accept a key this cycle
- o_kk_valid  out  1  schedule byte on o_kk is valid
- o_kk  out  8  schedule byte
- o_kk_idx  out  6  index of the byte on o_kk (55..0)
- i_kk_ready  in  1  consumer accepts o_kk this cycle

## Operation
- Schedule definition: W6 = i_key; Wg = perm(W(g+1)) for g = 5..0; kk[8g+j] = byte j of Wg XOR g (g in 0..6, j in 0..7).
- States: IDLE, EXPAND, STREAM.
- IDLE: o_key_ready=1. On i_key_valid, store i_key as W6, load cnt=5, go to EXPAND.
- EXPAND: each cycle store Wcnt = perm(W(cnt+1)) and decrement cnt. After storing W0, go to STREAM with idx=55. This takes 6 cycles.
- STREAM: o_kk_valid=1, o_kk = kk[idx], o_kk_idx = idx. On o_kk_valid & i_kk_ready:
  - if idx>0, decrement idx;
  - if idx==0, go to IDLE.
- o_kk and o_kk_idx hold stable while o_kk_valid & !i_kk_ready.
- i_key_valid outside IDLE is ignored. It has no effect on the current stream or on stored state.
- Reset values (all outputs): state=IDLE, o_key_ready=1, o_kk_valid=0, o_kk=0, o_kk_idx=0, cnt=0, idx=0. Group storage contents are don't-care after reset.
- i_rst in any state (mid-EXPAND or mid-STREAM) aborts the key. The next cycle shows reset values, and no partial bytes are emitted.
- Simultaneous i_rst and i_key_valid: reset wins, the key is not accepted.

## Timing
- Key accepted at edge T0 (i_key_valid & o_key_ready).
- EXPAND occupies cycles after T0 through edge T6.
- o_kk_valid is first high in the cycle after T6 with o_kk_idx=55. Latency is 7 cycles from acceptance to the first byte.
- With i_kk_ready held at 1, bytes 55..0 appear on 56 consecutive cycles.
- The handshake of byte 0 returns the block to IDLE. o_key_ready=1 in the next cycle, so the minimum key period is 63 cycles.
- o_key_ready is a registered state decode only; it has no combinational path from i_key_valid.
- o_kk_valid does not depend combinationally on i_kk_ready.
- o_kk is a registered group word selected by idx[5:3], with the byte selected by idx[2:0] and XORed with idx[5:3]. This mux/XOR path must close timing at the decipher clock.

## Structure
- Shared package csa_pkg holds:
  - NGRP=7 and KK_BYTES=56;
  - the state encoding (IDLE=0, EXPAND=1, STREAM=2);
  - the byte-extraction rule (byte j = bits [63-8j:56-8j]).
- Sub-module: one instance of the existing combinational key_perm (i_key/o_key). Its input is the most recently stored group word, and its output is written to Wcnt.
- Storage: 7x64 register array; 3-bit cnt; 6-bit idx; 2-bit state.

## Test plan
- Key 0x0000000000000000, i_kk_ready=1: 7 cycles after acceptance, bytes are 0x06 ×8 (idx 55..48), 0x05 ×8, … , 0x00 ×8 (idx 7..0). Then o_key_ready=1.
- Key 0xFFFFFFFFFFFFFFFF: stream is 0xF9 ×8, 0xFA ×8, 0xFB ×8, 0xFC ×8, 0xFD ×8, 0xFE ×8, 0xFF ×8.
- Backpressure: random keys with i_kk_ready toggled pseudo-randomly. Each 56-byte stream must match the C CSA key-schedule model in reverse order. o_kk and o_kk_idx must be stable while stalled, with no drops or duplicates.
- Busy-ignore: pulse i_key_valid with key 0x1122334455667788 during EXPAND and again during STREAM of key 0. The stream must still equal the all-zero-key stream.
- Reset mid-stream: assert i_rst after byte idx 30 is consumed. The next cycle must show o_kk_valid=0, o_key_ready=1, o_kk_idx=0. A following all-ones key must produce the full correct stream from idx 55.
- Back-to-back: present a new key in the first cycle o_key_ready returns high. It is accepted with no idle gap, and its first byte appears 7 cycles later.
